// File: rtl/adder_if.sv
// Operand/result bundle for the adder: operands and controls flow from the
// master into the adder, the registered result and flags flow back.
interface adder_if #(
    parameter int WIDTH = 8
);
    logic             valid_in;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             sat_en;
    logic             sat_signed;

    logic [WIDTH-1:0] y;
    logic             valid_out;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             negative;

    modport master (
        output valid_in, a, b, sub, sat_en, sat_signed,
        input  y, valid_out, carry, overflow, zero, negative
    );

    modport slave (
        input  valid_in, a, b, sub, sat_en, sat_signed,
        output y, valid_out, carry, overflow, zero, negative
    );
endinterface

// File: rtl/adder.sv
// Two-operand adder/subtractor with optional signed/unsigned saturation,
// one registered pipeline stage and status flags. Subtraction is a + ~b + 1
// so a single (WIDTH+1)-bit adder serves both operations, and the carry out
// doubles as "no borrow" when subtracting.
module adder #(
    parameter int WIDTH = 8
) (
    input  logic   clk,
    input  logic   rst,
    adder_if.slave bus
);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] SMAX     = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN     = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;
    logic             c;
    logic             ovf;
    logic [WIDTH-1:0] y_next;

    // Raw arithmetic plus the saturation decision for the current operands.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        y_next = '0;
        bb     = bus.sub ? ~bus.b : bus.b;
        sum    = {1'b0, bus.a} + {1'b0, bb} + {{WIDTH{1'b0}}, bus.sub};
        r      = sum[WIDTH-1:0];
        c      = sum[WIDTH];
        // Signed overflow: operands (after inversion) agree in sign, result does not.
        ovf    = (bus.a[WIDTH-1] == bb[WIDTH-1]) && (r[WIDTH-1] != bus.a[WIDTH-1]);

        y_next = r;
        if (bus.sat_en) begin
            if (bus.sat_signed) begin
                if (ovf) begin
                    y_next = bus.a[WIDTH-1] ? SMIN : SMAX;
                end
            end else begin
                if (!bus.sub && c) begin
                    y_next = ALL_ONES;
                end else if (bus.sub && !c) begin
                    y_next = '0;
                end
            end
        end
    end

    // Result/flag register: captures on valid_in, otherwise holds; valid_out
    // tracks valid_in one cycle late and reset clears everything.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            bus.y         <= '0;
            bus.valid_out <= 1'b0;
            bus.carry     <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.zero      <= 1'b0;
            bus.negative  <= 1'b0;
        end else begin
            bus.valid_out <= bus.valid_in;
            if (bus.valid_in) begin
                bus.y        <= y_next;
                // carry/overflow describe the unsaturated operation.
                bus.carry    <= c;
                bus.overflow <= ovf;
                // zero/negative describe the value actually presented on y.
                bus.zero     <= (y_next == '0);
                bus.negative <= y_next[WIDTH-1];
            end
        end
    end
endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: directed vectors from the test plan, then
// randomized traffic compared against an integer-arithmetic reference model.
module tb_adder;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    // Reference model state: what the registered outputs should show.
    logic [W-1:0] m_y;
    logic         m_valid, m_carry, m_ovf, m_zero, m_neg;

    adder_if #(.WIDTH(W)) bus ();

    adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Plain integer arithmetic: compute the exact unsigned and signed results
    // and clamp them, instead of modelling the hardware adder.
    function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s, input logic se, input logic ss,
                                   output logic [W-1:0] y, output logic c, output logic o);
        int ua = int'(a);
        int ub = int'(b);
        int sa = $signed(a);
        int sb = $signed(b);
        int ures;
        int sres;
        ures = s ? ua - ub : ua + ub;
        sres = s ? sa - sb : sa + sb;
        c = s ? (ua >= ub) : (ures > 255);
        o = (sres > 127) || (sres < -128);
        if (!se)
            y = ures[W-1:0];
        else if (!ss)
            y = (ures > 255) ? 8'hFF : (ures < 0) ? 8'h00 : ures[W-1:0];
        else
            y = (sres > 127) ? 8'h7F : (sres < -128) ? 8'h80 : sres[W-1:0];
    endfunction

    // One clock of stimulus: drive at negedge, update model at posedge,
    // compare all outputs just after the edge.
    task automatic step(input logic r, input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic se, input logic ss);
        logic [W-1:0] ey;
        logic         ec, eo;
        @(negedge clk);
        rst            = r;
        bus.valid_in   = v;
        bus.a          = a;
        bus.b          = b;
        bus.sub        = s;
        bus.sat_en     = se;
        bus.sat_signed = ss;
        @(posedge clk);
        if (r) begin
            m_y = '0; m_valid = 0; m_carry = 0; m_ovf = 0; m_zero = 0; m_neg = 0;
        end else begin
            m_valid = v;
            if (v) begin
                ref_op(a, b, s, se, ss, ey, ec, eo);
                m_y = ey; m_carry = ec; m_ovf = eo;
                m_zero = (ey == 0); m_neg = ey[W-1];
            end
        end
        #1;
        check("y",         bus.y,         m_y);
        check("valid_out", bus.valid_out, m_valid);
        check("carry",     bus.carry,     m_carry);
        check("overflow",  bus.overflow,  m_ovf);
        check("zero",      bus.zero,      m_zero);
        check("negative",  bus.negative,  m_neg);
    endtask

    typedef struct {
        logic [W-1:0] a, b;
        logic         s, se, ss;
        logic [W-1:0] y;
        logic         c, o, z, n;
    } vec_t;

    // Hand-derived expectations from the test plan.
    vec_t dir[$] = '{
        '{8'h01, 8'h01, 0, 0, 0, 8'h02, 0, 0, 0, 0},
        '{8'h02, 8'h03, 0, 0, 0, 8'h05, 0, 0, 0, 0},
        '{8'hFF, 8'h01, 0, 0, 0, 8'h00, 1, 0, 1, 0},
        '{8'hFF, 8'h01, 0, 1, 0, 8'hFF, 1, 0, 0, 1},
        '{8'h7F, 8'h01, 0, 0, 0, 8'h80, 0, 1, 0, 1},
        '{8'h7F, 8'h01, 0, 1, 1, 8'h7F, 0, 1, 0, 0},
        '{8'h80, 8'h01, 1, 1, 1, 8'h80, 1, 1, 0, 1},
        '{8'h05, 8'h03, 1, 0, 0, 8'h02, 1, 0, 0, 0},
        '{8'h03, 8'h05, 1, 0, 0, 8'hFE, 0, 0, 0, 1},
        '{8'h03, 8'h05, 1, 1, 0, 8'h00, 0, 0, 1, 0}
    };

    initial begin
        rst = 1'b1;
        bus.valid_in = 0; bus.a = '0; bus.b = '0;
        bus.sub = 0; bus.sat_en = 0; bus.sat_signed = 0;
        m_y = '0; m_valid = 0; m_carry = 0; m_ovf = 0; m_zero = 0; m_neg = 0;

        // Reset with valid operands applied: reset must win.
        step(1, 1, 8'hFF, 8'h01, 0, 0, 0);
        step(1, 1, 8'hFF, 8'h01, 0, 0, 0);
        check("rst_y", bus.y, 8'h00);
        check("rst_flags", {bus.valid_out, bus.carry, bus.overflow, bus.zero, bus.negative}, 5'b0);

        // Directed vectors back-to-back: one result per cycle, in order.
        foreach (dir[i]) begin
            step(0, 1, dir[i].a, dir[i].b, dir[i].s, dir[i].se, dir[i].ss);
            check($sformatf("dir%0d_y", i), bus.y, dir[i].y);
            check($sformatf("dir%0d_flags", i),
                  {bus.valid_out, bus.carry, bus.overflow, bus.zero, bus.negative},
                  {1'b1, dir[i].c, dir[i].o, dir[i].z, dir[i].n});
        end

        // Drop valid for one cycle: y holds the last result, valid_out low.
        step(0, 0, 8'h11, 8'h22, 0, 0, 0);
        check("hold_y", bus.y, 8'h00);
        check("hold_valid", bus.valid_out, 1'b0);
        check("hold_zero", bus.zero, 1'b1);

        // Stream interrupted by reset.
        step(0, 1, 8'h10, 8'h20, 0, 0, 0);
        check("pre_rst_y", bus.y, 8'h30);
        step(1, 1, 8'h40, 8'h01, 0, 0, 0);
        check("mid_rst_valid", bus.valid_out, 1'b0);
        check("mid_rst_y", bus.y, 8'h00);
        step(0, 1, 8'h40, 8'h01, 0, 0, 0);
        check("post_rst_y", bus.y, 8'h41);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 75),
                 W'($urandom), W'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
